// File: rtl/scc_pkg.sv
// Shared constants for the SCC core front end.
package scc_pkg;

    localparam int                 INSTR_W      = 32;
    localparam int                 DEF_ADDR_W   = 32;
    localparam logic [31:0]        DEF_RESET_PC = 32'h0000_0000;
    localparam int                 DEF_PC_STEP  = 4;

    // All-zero word; it is what decode sees on instruction out of reset.
    localparam logic [INSTR_W-1:0] NOP_INSTR    = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush beats push.
module fetch_fifo #(
    parameter int                DEPTH     = 2,
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(DEPTH + 1),
    localparam int               PTR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  count_q;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem_q[rd_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, sync imem request, queue to decode, redirect flush.
module fetch_unit
    import scc_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP    = DEF_PC_STEP,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  in_mem_addr,
    output logic               in_mem_en,
    input  logic [INSTR_W-1:0] in_mem,
    input  logic               stall,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    logic               issue, kill;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic [ENTRY_W-1:0] head;

    assign fifo_pop  = instr_valid && instr_ready;
    // A response landing in the redirect cycle belongs to the old path.
    assign kill      = inflight_q && branch_valid;
    assign fifo_push = inflight_q && !kill && (!fifo_full || fifo_pop);

    // Reserve a slot for the outstanding word so a landing response always fits.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(fifo_pop);
    assign issue     = !reset && !stall && !branch_valid
                       && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (branch_valid) begin
            pc_d = branch_target;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .DATA_W    (ENTRY_W),
        .RESET_VAL ({ADDR_W'(0), NOP_INSTR})
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (branch_valid),
        .wdata ({inflight_pc_q, in_mem}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_mem_addr = pc_q;
    assign in_mem_en   = issue;
    assign instr_valid = !fifo_empty;
    assign instruction = head[INSTR_W-1:0];
    assign instr_pc    = head[ENTRY_W-1 -: ADDR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard monitor on the decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_mem_addr;
    logic        in_mem_en;
    logic [31:0] in_mem;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   lost     = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_mem_addr   (in_mem_addr),
        .in_mem_en     (in_mem_en),
        .in_mem        (in_mem),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Synchronous memory, latency 1; garbage when not requested.
    always @(posedge clk) begin
        if (in_mem_en) in_mem <= memw(in_mem_addr);
        else           in_mem <= 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = memw(pc);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instruction, 32'd0);
        chk({tag, "_pc"},    instr_pc, 32'd0);
        chk({tag, "_en"},    32'(in_mem_en), 32'd0);
        chk({tag, "_addr"},  in_mem_addr, 32'd0);
    endtask

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got pc %h expected no entry", instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", instr_pc, mon_e.pc);
                chk("pop_instr", instruction, mon_e.instr);
            end
        end
        // A response that could not be queued would be silently lost.
        if (!reset && dut.inflight_q && !branch_valid && dut.fifo_full && !dut.fifo_pop)
            lost++;
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_valid = 1'b0;
        branch_target = '0; instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        neg();
        chk_reset_vals("rst");

        for (int p = 0; p <= 24; p += 4) expect_pc(32'(p));

        // Cycle 0: reset released.
        @(posedge clk); #1; reset = 1'b0;
        neg(); chk("c0_en", 32'(in_mem_en), 32'd1); chk("c0_addr", in_mem_addr, 32'h0);
        chk("c0_valid", 32'(instr_valid), 32'd0);
        step(); neg(); chk("c1_addr", in_mem_addr, 32'h4); chk("c1_valid", 32'(instr_valid), 32'd0);
        step(); neg(); chk("c2_valid", 32'(instr_valid), 32'd1); chk("c2_pc", instr_pc, 32'h0);
        for (int c = 3; c <= 5; c++) begin
            step(); neg();
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc", instr_pc, 32'(4 * (c - 2)));
        end

        // Decode back-pressure: queue fills to two, fetch stops, head holds.
        step(); instr_ready = 1'b0; neg(); chk("c6_en", 32'(in_mem_en), 32'd0);
        for (int c = 7; c <= 11; c++) begin
            step(); neg();
            chk("hold_en", 32'(in_mem_en), 32'd0);
            chk("hold_pc", instr_pc, 32'h10);
            chk("hold_instr", instruction, memw(32'h10));
            chk("hold_count", 32'(dut.fifo_count), 32'd2);
            chk("hold_addr", in_mem_addr, 32'h18);
        end
        step(); instr_ready = 1'b1; neg();
        chk("c12_pc", instr_pc, 32'h10); chk("c12_en", 32'(in_mem_en), 32'd1);
        chk("c12_addr", in_mem_addr, 32'h18);
        step(); neg(); chk("c13_pc", instr_pc, 32'h14);
        step(); neg(); chk("c14_pc", instr_pc, 32'h18);

        // Redirect with one entry queued and one word in flight, no pop.
        expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
        step(); instr_ready = 1'b0; branch_valid = 1'b1; branch_target = 32'h100;
        neg(); chk("c15_en", 32'(in_mem_en), 32'd0);
        step(); branch_valid = 1'b0; instr_ready = 1'b1;
        neg(); chk("c16_valid", 32'(instr_valid), 32'd0); chk("c16_addr", in_mem_addr, 32'h100);
        chk("c16_en", 32'(in_mem_en), 32'd1);
        step(); neg(); chk("c17_valid", 32'(instr_valid), 32'd0); chk("c17_addr", in_mem_addr, 32'h104);
        step(); neg(); chk("c18_valid", 32'(instr_valid), 32'd1); chk("c18_pc", instr_pc, 32'h100);
        step(); neg();

        // Redirect coincident with a pop of 0x108.
        for (int p = 0; p <= 16; p += 4) expect_pc(32'h200 + 32'(p));
        step(); branch_valid = 1'b1; branch_target = 32'h200;
        neg(); chk("c20_pc", instr_pc, 32'h108); chk("c20_en", 32'(in_mem_en), 32'd0);
        step(); branch_valid = 1'b0;
        neg(); chk("c21_valid", 32'(instr_valid), 32'd0); chk("c21_addr", in_mem_addr, 32'h200);
        step(); neg(); chk("c22_valid", 32'(instr_valid), 32'd0);
        step(); neg(); chk("c23_pc", instr_pc, 32'h200);

        // Stall mid-stream: in-flight word still lands, queue drains.
        step(); stall = 1'b1; neg(); chk("c24_en", 32'(in_mem_en), 32'd0); chk("c24_pc", instr_pc, 32'h204);
        step(); neg(); chk("c25_en", 32'(in_mem_en), 32'd0); chk("c25_pc", instr_pc, 32'h208);
        step(); neg(); chk("c26_en", 32'(in_mem_en), 32'd0); chk("c26_valid", 32'(instr_valid), 32'd0);
        step(); neg(); chk("c27_en", 32'(in_mem_en), 32'd0);
        step(); stall = 1'b0; neg(); chk("c28_en", 32'(in_mem_en), 32'd1); chk("c28_addr", in_mem_addr, 32'h20C);
        step(); neg();
        step(); neg(); chk("c30_pc", instr_pc, 32'h20C);

        // Redirect during stall to the top of the address space, then wrap.
        expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        step(); stall = 1'b1; branch_valid = 1'b1; branch_target = 32'hFFFF_FFF8;
        neg(); chk("c31_pc", instr_pc, 32'h210); chk("c31_en", 32'(in_mem_en), 32'd0);
        step(); branch_valid = 1'b0;
        neg(); chk("c32_en", 32'(in_mem_en), 32'd0); chk("c32_addr", in_mem_addr, 32'hFFFF_FFF8);
        step(); stall = 1'b0; neg(); chk("c33_addr", in_mem_addr, 32'hFFFF_FFF8);
        step(); neg(); chk("c34_addr", in_mem_addr, 32'hFFFF_FFFC);
        step(); neg(); chk("c35_addr", in_mem_addr, 32'h0); chk("c35_pc", instr_pc, 32'hFFFF_FFF8);
        step(); neg(); chk("c36_pc", instr_pc, 32'hFFFF_FFFC);
        step(); neg(); chk("c37_pc", instr_pc, 32'h0);

        // Reset mid-stream takes effect without waiting for a clock.
        step(); reset = 1'b1; #1;
        chk_reset_vals("midrst");
        chk("midrst_count", 32'(dut.fifo_count), 32'd0);
        step(); neg();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("no_lost_response", 32'(lost), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
